// File: rtl/vga_timing_pkg.sv
// Shared timing constants for the VGA timing generator (640x480@60 defaults).
package vga_timing_pkg;

    localparam int CNT_W     = 10;
    localparam int MAX_TOTAL = 1024;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    function automatic int line_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    localparam int H_TOTAL = line_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int V_TOTAL = line_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage

// File: rtl/vga_timing_if.sv
// Timing bundle between the VGA timing generator and the pixel/colour path.
interface vga_timing_if;
    import vga_timing_pkg::*;

    logic             i_enable;
    logic             o_pix_tick;
    logic [CNT_W-1:0] o_hcount;
    logic [CNT_W-1:0] o_vcount;
    logic             o_blank;
    logic             o_hsync;
    logic             o_vsync;
    logic             o_frame_end;

    modport master (
        input  i_enable,
        output o_pix_tick, o_hcount, o_vcount, o_blank, o_hsync, o_vsync, o_frame_end
    );

    modport slave (
        output i_enable,
        input  o_pix_tick, o_hcount, o_vcount, o_blank, o_hsync, o_vsync, o_frame_end
    );
endinterface

// File: rtl/vga_timing_gen_sync_delay_line.sv
// Fixed-depth register chain that realigns the syncs with the registered colour path.
module sync_delay_line #(
    parameter int               WIDTH     = 2,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign o_q = i_d;
        end else begin : g_chain
            logic [WIDTH-1:0] r_stage [DEPTH];

            // Shift every clock, independent of the pixel tick.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_stage[i] <= RESET_VAL;
                    end
                end else begin
                    r_stage[0] <= i_d;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign o_q = r_stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel-tick divider, H/V counters, blank and delayed sync decode.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   CLK_DIV    = 4,
    parameter int   H_ACTIVE   = DEF_H_ACTIVE,
    parameter int   H_FP       = DEF_H_FP,
    parameter int   H_SYNC     = DEF_H_SYNC,
    parameter int   H_BP       = DEF_H_BP,
    parameter int   V_ACTIVE   = DEF_V_ACTIVE,
    parameter int   V_FP       = DEF_V_FP,
    parameter int   V_SYNC     = DEF_V_SYNC,
    parameter int   V_BP       = DEF_V_BP,
    parameter logic SYNC_POL   = 1'b0,
    parameter int   SYNC_DELAY = 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    vga_timing_if.master bus
);

    localparam int H_TOT = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOT = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOT - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOT - 1);
    localparam logic [CNT_W:0]   H_ACT    = (CNT_W+1)'(H_ACTIVE);
    localparam logic [CNT_W:0]   V_ACT    = (CNT_W+1)'(V_ACTIVE);
    localparam logic [CNT_W:0]   HS_BEG   = (CNT_W+1)'(H_ACTIVE + H_FP);
    localparam logic [CNT_W:0]   HS_END   = (CNT_W+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W:0]   VS_BEG   = (CNT_W+1)'(V_ACTIVE + V_FP);
    localparam logic [CNT_W:0]   VS_END   = (CNT_W+1)'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [1:0]       SYNC_IDLE = {2{~SYNC_POL}};

    generate
        if (H_TOT > MAX_TOTAL || V_TOT > MAX_TOTAL) begin : g_bad_total
            $error("vga_timing_gen: H/V total exceeds counter range");
        end
        if (CLK_DIV < 1) begin : g_bad_div
            $error("vga_timing_gen: CLK_DIV must be at least 1");
        end
        if (SYNC_DELAY < 0 || SYNC_DELAY > 4) begin : g_bad_delay
            $error("vga_timing_gen: SYNC_DELAY must be 0..4");
        end
    endgenerate

    logic [DIV_W-1:0] r_div;
    logic             r_pix_tick;
    logic [CNT_W-1:0] r_hcount;
    logic [CNT_W-1:0] r_vcount;

    logic [DIV_W-1:0] w_div_next;
    logic             w_hs_raw;
    logic             w_vs_raw;
    logic [1:0]       w_sync_in;
    logic [1:0]       w_sync_q;

    // Next divider value; wraps after CLK_DIV-1.
    always_comb begin
        w_div_next = '0;
        if (r_div == DIV_LAST) begin
            w_div_next = '0;
        end else begin
            w_div_next = r_div + 1'b1;
        end
    end

    // Divider, pixel tick and raster counters; everything holds while disabled.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div      <= '0;
            r_pix_tick <= 1'b0;
            r_hcount   <= '0;
            r_vcount   <= '0;
        end else if (bus.i_enable) begin
            r_div      <= w_div_next;
            r_pix_tick <= (w_div_next == DIV_LAST);
            if (r_pix_tick) begin
                if (r_hcount == H_LAST) begin
                    r_hcount <= '0;
                    r_vcount <= (r_vcount == V_LAST) ? '0 : r_vcount + 1'b1;
                end else begin
                    r_hcount <= r_hcount + 1'b1;
                end
            end
        end
    end

    // Raw sync decode, forced idle while disabled.
    always_comb begin
        w_hs_raw  = bus.i_enable && ({1'b0, r_hcount} >= HS_BEG) && ({1'b0, r_hcount} < HS_END);
        w_vs_raw  = bus.i_enable && ({1'b0, r_vcount} >= VS_BEG) && ({1'b0, r_vcount} < VS_END);
        w_sync_in = {(w_hs_raw ? SYNC_POL : ~SYNC_POL), (w_vs_raw ? SYNC_POL : ~SYNC_POL)};
    end

    sync_delay_line #(
        .WIDTH     (2),
        .DEPTH     (SYNC_DELAY),
        .RESET_VAL (SYNC_IDLE)
    ) u_sync_delay (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (w_sync_in),
        .o_q     (w_sync_q)
    );

    // The stored tick is masked so a disabled generator never reports a pixel.
    assign bus.o_pix_tick  = r_pix_tick & bus.i_enable;
    assign bus.o_hcount    = r_hcount;
    assign bus.o_vcount    = r_vcount;
    assign bus.o_frame_end = r_pix_tick & bus.i_enable & (r_hcount == H_LAST) & (r_vcount == V_LAST);
    assign bus.o_blank     = ~bus.i_enable | ~i_rst_n
                           | ({1'b0, r_hcount} >= H_ACT) | ({1'b0, r_vcount} >= V_ACT);
    assign bus.o_hsync     = w_sync_q[1];
    assign bus.o_vsync     = w_sync_q[0];

endmodule
